dht11_sampler: RTL
==================

// Module: dht11_sampler
// PURPOSE
//  Single-wire DHT11 temperature/humidity reader, directly downstream of the periodic update-pulse generator.
//  Each rising edge of update starts one sensor transaction: start pulse, response handshake, 40 data bits, checksum.
//  Validated readings are latched for the display/UART stages; failed transactions leave the previous readings intact.
//  Open-drain line handled at top level: this block only requests drive-low; the pad tristates otherwise.
// PARAMETERS
//  START_LOW_CYCLES  900_000  host drive-low time (18 ms @ 50 MHz)
//  TIMEOUT_CYCLES    10_000   max wait for any expected line edge (200 us)
//  BIT_THRESH_CYCLES 2_500    high-phase length above which a bit is 1 (50 us)
// PORTS
//  clk50          in   1  50 MHz system clock
//  reset          in   1  synchronous, active-high reset
//  update         in   1  trigger from update generator; multi-cycle level, rising edge used
//  dht_in         in   1  raw sensor line (asynchronous)
//  dht_drive_low  out  1  1 = pad drives line low, 0 = release (pull-up)
//  humidity_int   out  8  byte 0 of last good frame
//  humidity_dec   out  8  byte 1 of last good frame
//  temp_int       out  8  byte 2 of last good frame
//  temp_dec       out  8  byte 3 of last good frame
//  data_valid     out  1  one-cycle pulse when new readings are latched
//  checksum_err   out  1  result of last completed transaction: 1 = bad checksum
//  timeout_err    out  1  result of last completed transaction: 1 = timed out
//  busy           out  1  high from trigger acceptance until return to IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, counters = 0, shift register = 0, update edge detector = 0.
//  Reset mid-transaction aborts immediately; dht_drive_low = 0 in the same cycle.
//  dht_in passes through a 2-FF synchroniser. All edge decisions use the synchronised value (2-cycle latency).
//  Trigger: update sampled and registered; start only on 0->1 in IDLE. Edges while busy are ignored (not queued).
//  FSM states and transitions:
//   IDLE      : on trigger -> START_LOW; busy=1; clear checksum_err/timeout_err; cycle counter=0
//   START_LOW : dht_drive_low=1 for START_LOW_CYCLES cycles -> WAIT_ACK
//   WAIT_ACK  : released; wait for line low (sensor ack) -> ACK_LOW
//   ACK_LOW   : wait for line high -> ACK_HIGH
//   ACK_HIGH  : wait for line low -> BIT_LOW
//   BIT_LOW   : wait for line high -> BIT_HIGH; high counter=0
//   BIT_HIGH  : count high cycles; on line low shift in bit (count > BIT_THRESH_CYCLES), bit index+1
//               bit 40 shifted in -> CHECK, otherwise -> BIT_LOW
//   CHECK     : sum = (b0+b1+b2+b3) mod 256 (8-bit wrap)
//               if sum == b4: latch 4 bytes, pulse data_valid, else checksum_err=1; -> IDLE
//  Data is shifted MSB first; b0 is the first byte received.
//  Timeout: each wait state (WAIT_ACK..BIT_HIGH) counts cycles since entry.
//   Reaching TIMEOUT_CYCLES -> timeout_err=1, dht_drive_low=0, -> IDLE.
//   The 40-bit frame is discarded and outputs are unchanged.
//  busy deasserts on entry to IDLE. data_valid and the error flags update in the same cycle.
//  Error flags hold until the next trigger. data_valid is never asserted with either error flag.
//  Bit high count saturates at TIMEOUT_CYCLES, so there is no wrap.
//  The bit index counter is 6 bits and is cleared at START_LOW.
//  dht_drive_low is 1 only in START_LOW.
// TESTING
//  Behavioural DHT11 model on dht_in: 80us low/80us high ack, bits = 50us low + 26us (0) / 70us (1) high.
//  1 Frame 0x37,0x00,0x19,0x00,0x50 -> humidity_int=55, temp_int=25, one data_valid pulse, both errs 0, busy falls.
//  2 Frame 0x37,0x00,0x19,0x00,0x51 -> checksum_err=1, no data_valid, outputs keep previous values (55/25).
//  3 Sensor silent after start -> timeout_err=1 TIMEOUT_CYCLES+2..3 cycles after release, dht_drive_low=0, IDLE.
//  4 Sum wrap: 0xFF,0x01,0x10,0x05,0x15 -> accepted (sum mod 256 = 0x15), data_valid pulses.
//  5 Second update edge during BIT_HIGH -> ignored; exactly one transaction; next edge after IDLE starts a new one.
//  6 Reset asserted in START_LOW and in BIT_HIGH -> dht_drive_low=0 and all outputs 0 the next cycle; restart reads OK.

Source files
------------

// File: rtl/dht11_sampler.sv
// dht11_sampler: single-wire DHT11 reader. Each rising edge of update runs one
// transaction (host start pulse, sensor handshake, 40 data bits, checksum) and
// latches the four data bytes only when the checksum matches. The block never
// drives the line high; it only asks the pad to pull low during the start pulse.

module dht11_sampler #(
   parameter int START_LOW_CYCLES  = 900_000,
   parameter int TIMEOUT_CYCLES    = 10_000,
   parameter int BIT_THRESH_CYCLES = 2_500
) (
   input  logic       clk50,
   input  logic       reset,
   input  logic       update,
   input  logic       dht_in,
   output logic       dht_drive_low,
   output logic [7:0] humidity_int,
   output logic [7:0] humidity_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec,
   output logic       data_valid,
   output logic       checksum_err,
   output logic       timeout_err,
   output logic       busy
);

   localparam int CNT_MAX = (START_LOW_CYCLES > TIMEOUT_CYCLES) ? START_LOW_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] START_LAST    = CW'(START_LOW_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] BIT_THRESH    = CW'(BIT_THRESH_CYCLES);
   localparam logic [CW-1:0] CNT_ONE       = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START_LOW,
      WAIT_ACK,
      ACK_LOW,
      ACK_HIGH,
      BIT_LOW,
      BIT_HIGH,
      CHECK
   } stateType;

   stateType state;
   stateType nextState;

   logic          dhtMeta;
   logic          dhtSync;
   logic          dhtPrev;
   logic          updReg;
   logic          updPrev;
   logic [CW-1:0] cycleCnt;
   logic [5:0]    bitIdx;
   logic [39:0]   shiftReg;

   logic       trigger;
   logic       lineRise;
   logic       lineFall;
   logic       timedOut;
   logic       bitValue;
   logic [7:0] frameSum;
   logic       frameOk;
   logic       startTxn;
   logic       shiftEn;
   logic       latchEn;
   logic       csFail;
   logic       toFail;

   assign trigger  = updReg & ~updPrev;
   assign lineRise = ~dhtPrev & dhtSync;
   assign lineFall = dhtPrev & ~dhtSync;
   assign timedOut = (cycleCnt >= TIMEOUT_LIMIT);
   assign bitValue = (cycleCnt > BIT_THRESH);
   assign frameSum = shiftReg[39:32] + shiftReg[31:24] + shiftReg[23:16] + shiftReg[15:8];
   assign frameOk  = (frameSum == shiftReg[7:0]);

   assign busy          = (state != IDLE);
   assign dht_drive_low = (state == START_LOW);

   // Bring the asynchronous sensor line and the update trigger into the clk50
   // domain, keeping one extra stage of each so edges can be detected.
   always_ff @(posedge clk50) begin
      if (reset) begin
         dhtMeta <= 1'b0;
         dhtSync <= 1'b0;
         dhtPrev <= 1'b0;
         updReg  <= 1'b0;
         updPrev <= 1'b0;
      end else begin
         dhtMeta <= dht_in;
         dhtSync <= dhtMeta;
         dhtPrev <= dhtSync;
         updReg  <= update;
         updPrev <= updReg;
      end
   end

   // Transaction state register; a synchronous reset drops straight back to
   // IDLE, which also releases the line on the following cycle.
   always_ff @(posedge clk50) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Sequencing of the transaction. Every wait state reacts to a line edge
   // first and only gives up when its time-in-state counter hits the limit.
   always_comb begin
      nextState = state;
      startTxn  = 1'b0;
      shiftEn   = 1'b0;
      latchEn   = 1'b0;
      csFail    = 1'b0;
      toFail    = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               nextState = START_LOW;
               startTxn  = 1'b1;
            end
         end
         START_LOW: begin
            if (cycleCnt == START_LAST) begin
               nextState = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (lineFall) begin
               nextState = ACK_LOW;
            end else if (timedOut) begin
               nextState = IDLE;
               toFail    = 1'b1;
            end
         end
         ACK_LOW: begin
            if (lineRise) begin
               nextState = ACK_HIGH;
            end else if (timedOut) begin
               nextState = IDLE;
               toFail    = 1'b1;
            end
         end
         ACK_HIGH: begin
            if (lineFall) begin
               nextState = BIT_LOW;
            end else if (timedOut) begin
               nextState = IDLE;
               toFail    = 1'b1;
            end
         end
         BIT_LOW: begin
            if (lineRise) begin
               nextState = BIT_HIGH;
            end else if (timedOut) begin
               nextState = IDLE;
               toFail    = 1'b1;
            end
         end
         BIT_HIGH: begin
            if (lineFall) begin
               shiftEn   = 1'b1;
               nextState = (bitIdx == 6'd39) ? CHECK : BIT_LOW;
            end else if (timedOut) begin
               nextState = IDLE;
               toFail    = 1'b1;
            end
         end
         CHECK: begin
            nextState = IDLE;
            if (frameOk) begin
               latchEn = 1'b1;
            end else begin
               csFail = 1'b1;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Time-in-state counter: restarts on every state change. It free-runs
   // during the start pulse and saturates at the timeout limit elsewhere, so
   // it doubles as the high-phase length for bit decisions without wrapping.
   always_ff @(posedge clk50) begin
      if (reset) begin
         cycleCnt <= '0;
      end else if (nextState != state) begin
         cycleCnt <= '0;
      end else if (state == START_LOW) begin
         cycleCnt <= cycleCnt + CNT_ONE;
      end else if (cycleCnt < TIMEOUT_LIMIT) begin
         cycleCnt <= cycleCnt + CNT_ONE;
      end
   end

   // Frame assembly: bits arrive MSB first, so the first byte received ends
   // up in the top byte of the shift register once all 40 are in.
   always_ff @(posedge clk50) begin
      if (reset) begin
         bitIdx   <= 6'd0;
         shiftReg <= 40'd0;
      end else if (startTxn) begin
         bitIdx   <= 6'd0;
         shiftReg <= 40'd0;
      end else if (shiftEn) begin
         bitIdx   <= bitIdx + 6'd1;
         shiftReg <= {shiftReg[38:0], bitValue};
      end
   end

   // Result registers: readings change only on a good checksum, and the
   // status flags describe the most recent finished transaction until the
   // next one is accepted. They all settle in the cycle busy drops.
   always_ff @(posedge clk50) begin
      if (reset) begin
         humidity_int <= 8'd0;
         humidity_dec <= 8'd0;
         temp_int     <= 8'd0;
         temp_dec     <= 8'd0;
         data_valid   <= 1'b0;
         checksum_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         data_valid <= latchEn;
         if (latchEn) begin
            humidity_int <= shiftReg[39:32];
            humidity_dec <= shiftReg[31:24];
            temp_int     <= shiftReg[23:16];
            temp_dec     <= shiftReg[15:8];
         end
         if (startTxn) begin
            checksum_err <= 1'b0;
            timeout_err  <= 1'b0;
         end else begin
            if (csFail) begin
               checksum_err <= 1'b1;
            end
            if (toFail) begin
               timeout_err <= 1'b1;
            end
         end
      end
   end

endmodule
